// File: rtl/stream_config_sequencer_pkg.sv
// Shared types for the stream configuration sequencer: field types and FSM encoding.
package stream_config_sequencer_pkg;

  localparam int DEF_SELECT_WIDTH = 4;
  localparam int DEF_TYPE_WIDTH   = 8;
  localparam int DEF_MAX_INFLIGHT = 15;

  typedef logic [DEF_SELECT_WIDTH-1:0] select_t;
  typedef logic [DEF_TYPE_WIDTH-1:0]   type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SEL,
    ST_TYPE
  } seq_state_t;

endpackage

// File: rtl/stream_config_sequencer_inflight_counter.sv
// Saturating up/down count of packets inside the datapath, with sticky
// overflow (bit0) and underflow (bit1) flags.
module stream_config_sequencer_inflight_counter #(
  parameter int MAX_INFLIGHT = 15,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_in_start,
  input  logic             pkt_out_done,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic up;
  logic down;

  // A start and a done in the same cycle cancel out.
  assign up   = pkt_in_start & ~pkt_out_done;
  assign down = pkt_out_done & ~pkt_in_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      err   <= '0;
    end else if (up) begin
      if (count == MAX_CNT) err[0] <= 1'b1;
      else                  count  <= count + CNT_W'(1);
    end else if (down) begin
      if (count == '0) err[1] <= 1'b1;
      else             count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_config_sequencer.sv
// Applies a new stream select/type only once the datapath has drained, then
// hands the select to both consumers before issuing the type.
//
// state | meaning
// IDLE  | ready for a config request, datapath open
// DRAIN | input held, waiting for the in-flight count to reach zero
// SEL   | select offered to input- and output-side consumers
// TYPE  | type offered to the datapath, input still held
module stream_config_sequencer
  import stream_config_sequencer_pkg::*;
#(
  parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
  parameter int TYPE_WIDTH   = DEF_TYPE_WIDTH,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [SELECT_WIDTH-1:0] cfg_select,
  input  logic [TYPE_WIDTH-1:0]   cfg_type,
  input  logic                    pkt_in_start,
  input  logic                    pkt_out_done,
  output logic                    in_hold,
  output logic                    in_sel_valid,
  input  logic                    in_sel_ready,
  output logic                    out_sel_valid,
  input  logic                    out_sel_ready,
  output logic [SELECT_WIDTH-1:0] sel_data,
  output logic                    type_valid,
  input  logic                    type_ready,
  output logic [TYPE_WIDTH-1:0]   type_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        inflight,
  output logic [1:0]              err
);

  seq_state_t              state, state_nxt;
  logic [SELECT_WIDTH-1:0] sel_nxt;
  logic [TYPE_WIDTH-1:0]   type_nxt;
  logic                    hold_nxt;
  logic                    in_sel_valid_nxt, out_sel_valid_nxt, type_valid_nxt;
  logic                    in_done, out_done, in_done_nxt, out_done_nxt;
  logic                    in_fin, out_fin;

  stream_config_sequencer_inflight_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_inflight (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_in_start (pkt_in_start),
    .pkt_out_done (pkt_out_done),
    .count        (inflight),
    .err          (err)
  );

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // A channel counts as finished once its flag is set or its handshake is happening now.
  assign in_fin  = in_done  | (in_sel_valid  & in_sel_ready);
  assign out_fin = out_done | (out_sel_valid & out_sel_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sel_data      <= '0;
      type_data     <= '0;
      in_hold       <= 1'b0;
      in_sel_valid  <= 1'b0;
      out_sel_valid <= 1'b0;
      type_valid    <= 1'b0;
      in_done       <= 1'b0;
      out_done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      sel_data      <= sel_nxt;
      type_data     <= type_nxt;
      in_hold       <= hold_nxt;
      in_sel_valid  <= in_sel_valid_nxt;
      out_sel_valid <= out_sel_valid_nxt;
      type_valid    <= type_valid_nxt;
      in_done       <= in_done_nxt;
      out_done      <= out_done_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    sel_nxt           = sel_data;
    type_nxt          = type_data;
    hold_nxt          = in_hold;
    in_sel_valid_nxt  = in_sel_valid;
    out_sel_valid_nxt = out_sel_valid;
    type_valid_nxt    = type_valid;
    in_done_nxt       = in_done;
    out_done_nxt      = out_done;

    unique case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          sel_nxt      = cfg_select;
          type_nxt     = cfg_type;
          hold_nxt     = 1'b1;
          in_done_nxt  = 1'b0;
          out_done_nxt = 1'b0;
          state_nxt    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        hold_nxt = 1'b1;
        // A start this cycle means the count is about to rise again.
        if ((inflight == '0) && !pkt_in_start) begin
          in_sel_valid_nxt  = 1'b1;
          out_sel_valid_nxt = 1'b1;
          state_nxt         = ST_SEL;
        end
      end
      ST_SEL: begin
        if (in_sel_valid && in_sel_ready) begin
          in_sel_valid_nxt = 1'b0;
          in_done_nxt      = 1'b1;
        end
        if (out_sel_valid && out_sel_ready) begin
          out_sel_valid_nxt = 1'b0;
          out_done_nxt      = 1'b1;
        end
        if (in_fin && out_fin) begin
          type_valid_nxt = 1'b1;
          state_nxt      = ST_TYPE;
        end
      end
      ST_TYPE: begin
        if (type_ready) begin
          type_valid_nxt = 1'b0;
          hold_nxt       = 1'b0;
          state_nxt      = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stream_config_sequencer.sv
// Randomised scoreboard bench for stream_config_sequencer with a phase-level reference model.
module tb_stream_config_sequencer;

  localparam int SW   = 4;
  localparam int TW   = 8;
  localparam int MAXI = 15;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW-1:0] cfg_select = '0;
  logic [TW-1:0] cfg_type = '0;
  logic          pkt_in_start = 1'b0;
  logic          pkt_out_done = 1'b0;
  logic          in_hold;
  logic          in_sel_valid;
  logic          in_sel_ready = 1'b1;
  logic          out_sel_valid;
  logic          out_sel_ready = 1'b1;
  logic [SW-1:0] sel_data;
  logic          type_valid;
  logic          type_ready = 1'b1;
  logic [TW-1:0] type_data;
  logic          busy;
  logic [CW-1:0] inflight;
  logic [1:0]    err;

  always #5 clk = ~clk;

  stream_config_sequencer #(
    .SELECT_WIDTH(SW),
    .TYPE_WIDTH  (TW),
    .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_select   (cfg_select),
    .cfg_type     (cfg_type),
    .pkt_in_start (pkt_in_start),
    .pkt_out_done (pkt_out_done),
    .in_hold      (in_hold),
    .in_sel_valid (in_sel_valid),
    .in_sel_ready (in_sel_ready),
    .out_sel_valid(out_sel_valid),
    .out_sel_ready(out_sel_ready),
    .sel_data     (sel_data),
    .type_valid   (type_valid),
    .type_ready   (type_ready),
    .type_data    (type_data),
    .busy         (busy),
    .inflight     (inflight),
    .err          (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: request phase (0 idle, 1 draining, 2 selects offered, 3 type offered).
  int            m_cnt;
  logic [1:0]    m_err;
  int            m_phase;
  bit            m_in_done, m_out_done;
  logic [SW-1:0] m_sel;
  logic [TW-1:0] m_type;
  logic [SW-1:0] q_in[$];
  logic [SW-1:0] q_out[$];
  logic [TW-1:0] q_type[$];
  bit            cfg_hs_last;
  bit            e_in, e_out, e_t;
  int            cnt_before;
  logic [SW-1:0] exp_s;
  logic [TW-1:0] exp_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_err = '0; m_phase = 0; m_in_done = 0; m_out_done = 0;
      m_sel = '0; m_type = '0; cfg_hs_last = 0;
      q_in.delete(); q_out.delete(); q_type.delete();
    end else begin
      e_in  = (m_phase == 2) && !m_in_done;
      e_out = (m_phase == 2) && !m_out_done;
      e_t   = (m_phase == 3);
      check("inflight", 32'(inflight), 32'(m_cnt));
      check("err", 32'(err), 32'(m_err));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("in_hold", 32'(in_hold), 32'(m_phase != 0));
      check("cfg_ready", 32'(cfg_ready), 32'(m_phase == 0));
      check("in_sel_valid", 32'(in_sel_valid), 32'(e_in));
      check("out_sel_valid", 32'(out_sel_valid), 32'(e_out));
      check("type_valid", 32'(type_valid), 32'(e_t));
      check("sel_data_stable", 32'(sel_data), 32'(m_sel));
      check("type_data_stable", 32'(type_data), 32'(m_type));

      if (e_in && in_sel_ready) begin
        check("sb_in_sel_present", 32'(q_in.size() != 0), 32'(1));
        if (q_in.size() != 0) begin
          exp_s = q_in.pop_front();
          check("sb_in_sel_data", 32'(sel_data), 32'(exp_s));
        end
      end
      if (e_out && out_sel_ready) begin
        check("sb_out_sel_present", 32'(q_out.size() != 0), 32'(1));
        if (q_out.size() != 0) begin
          exp_s = q_out.pop_front();
          check("sb_out_sel_data", 32'(sel_data), 32'(exp_s));
        end
      end
      if (e_t && type_ready) begin
        check("sb_type_present", 32'(q_type.size() != 0), 32'(1));
        if (q_type.size() != 0) begin
          exp_t = q_type.pop_front();
          check("sb_type_data", 32'(type_data), 32'(exp_t));
        end
      end

      cnt_before = m_cnt;
      if (pkt_in_start && !pkt_out_done) begin
        if (m_cnt == MAXI) m_err[0] = 1'b1;
        else m_cnt++;
      end else if (pkt_out_done && !pkt_in_start) begin
        if (m_cnt == 0) m_err[1] = 1'b1;
        else m_cnt--;
      end

      cfg_hs_last = 0;
      case (m_phase)
        0: if (cfg_valid) begin
          m_sel = cfg_select;
          m_type = cfg_type;
          q_in.push_back(cfg_select);
          q_out.push_back(cfg_select);
          q_type.push_back(cfg_type);
          m_phase = 1;
          cfg_hs_last = 1;
        end
        1: if (cnt_before == 0 && !pkt_in_start) begin
          m_phase = 2;
          m_in_done = 0;
          m_out_done = 0;
        end
        2: begin
          if (e_in && in_sel_ready) m_in_done = 1;
          if (e_out && out_sel_ready) m_out_done = 1;
          if (m_in_done && m_out_done) m_phase = 3;
        end
        3: if (type_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE; pkt_out_done pulses at the given cycles after capture.
  task automatic run_req(input logic [SW-1:0] s, input logic [TW-1:0] t, input bit start_cap,
                         input int d0, input int d1, input int d2,
                         output int first_sel, output int hold_rel);
    tick();
    cfg_valid = 1'b1; cfg_select = s; cfg_type = t; pkt_in_start = start_cap;
    tick();
    cfg_valid = 1'b0; pkt_in_start = 1'b0;
    first_sel = -1;
    hold_rel = -1;
    for (int c = 1; c <= 30; c++) begin
      pkt_out_done = (c == d0) || (c == d1) || (c == d2);
      @(negedge clk);
      if (first_sel < 0 && in_sel_valid) first_sel = c;
      if (hold_rel < 0 && !in_hold) hold_rel = c;
      tick();
    end
    pkt_out_done = 1'b0;
  endtask

  task automatic settle(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (cfg_valid && cfg_hs_last) cfg_valid = 1'b0;
      in_sel_ready = 1'b1; out_sel_ready = 1'b1; type_ready = 1'b1;
      pkt_in_start = 1'b0;
      if (!cfg_valid && !busy && inflight == '0) begin
        pkt_out_done = 1'b0;
        ok = 1;
      end else begin
        pkt_out_done = (inflight != '0);
      end
    end
    pkt_out_done = 1'b0;
    check(name, 32'(ok), 32'(1));
  endtask

  task automatic wait_valid(input bit want_type, output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (want_type ? type_valid : (in_sel_valid || out_sel_valid)) ok = 1;
    end
  endtask

  int fs, hr, tv_cycles;
  bit ok;

  initial begin
    #12;
    check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    check("rst_in_hold", 32'(in_hold), 32'(0));
    check("rst_valids", 32'({in_sel_valid, out_sel_valid, type_valid}), 32'(0));
    check("rst_data", 32'({sel_data, type_data}), 32'(0));
    check("rst_inflight_err", 32'({inflight, err}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Empty datapath, readies high.
    run_req(4'd3, 8'h5A, 1'b0, -1, -1, -1, fs, hr);
    check("empty_sel_cycle", 32'(fs), 32'(2));
    check("empty_hold_release", 32'(hr), 32'(4));
    settle("settle_1");

    // Three packets in flight, drained at +5, +9, +12.
    pkt_in_start = 1'b1;
    repeat (3) tick();
    pkt_in_start = 1'b0;
    run_req(4'd9, 8'hC3, 1'b0, 5, 9, 12, fs, hr);
    check("drain3_sel_cycle", 32'(fs), 32'(14));
    check("drain3_hold_release", 32'(hr), 32'(16));
    settle("settle_2");

    // Start in the capture cycle must still be drained.
    run_req(4'd6, 8'h11, 1'b1, 3, -1, -1, fs, hr);
    check("capstart_sel_cycle", 32'(fs), 32'(5));
    check("capstart_hold_release", 32'(hr), 32'(7));
    settle("settle_3");

    // Skewed select readies and a stalled type.
    in_sel_ready = 1'b1; out_sel_ready = 1'b0; type_ready = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_select = 4'hE; cfg_type = 8'hA7;
    tick();
    cfg_valid = 1'b0;
    wait_valid(1'b0, ok);
    check("skew_sel_timeout", 32'(ok), 32'(1));
    repeat (3) tick();
    out_sel_ready = 1'b1;
    wait_valid(1'b1, ok);
    check("skew_type_timeout", 32'(ok), 32'(1));
    repeat (2) tick();
    type_ready = 1'b1;
    tv_cycles = 2;
    for (int i = 0; i < 10 && type_valid; i++) begin
      @(negedge clk);
      if (type_valid) tv_cycles++;
    end
    check("skew_type_held_cycles", 32'(tv_cycles), 32'(3));
    settle("settle_4");

    // Randomised traffic, requests and backpressure.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (cfg_valid && cfg_hs_last) cfg_valid = 1'b0;
      else if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_select = SW'($urandom);
        cfg_type = TW'($urandom);
      end
      in_sel_ready = 1'($urandom);
      out_sel_ready = 1'($urandom);
      type_ready = 1'($urandom);
      pkt_in_start = !in_hold && (m_cnt < MAXI - 1) && ($urandom_range(0, 3) == 0);
      pkt_out_done = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
    end
    settle("settle_rand");

    // Counter saturation, underflow and simultaneous pulses.
    pkt_in_start = 1'b1;
    repeat (16) tick();
    pkt_in_start = 1'b0;
    check("ovf_inflight", 32'(inflight), 32'(15));
    check("ovf_err", 32'(err), 32'(1));
    pkt_out_done = 1'b1;
    repeat (16) tick();
    pkt_out_done = 1'b0;
    check("unf_inflight", 32'(inflight), 32'(0));
    check("unf_err", 32'(err), 32'(3));
    pkt_in_start = 1'b1;
    repeat (3) tick();
    pkt_out_done = 1'b1;
    repeat (4) tick();
    pkt_in_start = 1'b0; pkt_out_done = 1'b0;
    check("simul_inflight", 32'(inflight), 32'(3));
    settle("settle_5");

    // Reset while the selects are outstanding.
    in_sel_ready = 1'b0; out_sel_ready = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_select = 4'h5; cfg_type = 8'h3C;
    tick();
    cfg_valid = 1'b0;
    wait_valid(1'b0, ok);
    check("rstsel_timeout", 32'(ok), 32'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstsel_valids", 32'({in_sel_valid, out_sel_valid, type_valid}), 32'(0));
    check("rstsel_in_hold", 32'(in_hold), 32'(0));
    check("rstsel_err", 32'(err), 32'(0));
    check("rstsel_cfg_ready", 32'(cfg_ready), 32'(1));
    repeat (2) tick();
    rst_n = 1'b1;
    in_sel_ready = 1'b1; out_sel_ready = 1'b1;
    run_req(4'hB, 8'h96, 1'b0, -1, -1, -1, fs, hr);
    check("post_rst_sel_cycle", 32'(fs), 32'(2));
    check("post_rst_hold_release", 32'(hr), 32'(4));
    settle("settle_6");
    check("sb_leftover", 32'(q_in.size() + q_out.size() + q_type.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
